// File: rtl/cache_write_buffer.sv
// cache_write_buffer
//
// Posted-write buffer between the 4-way cache and backing RAM. Stores from
// the cache are queued in a small circular FIFO and drained one at a time
// to memory over a req/ack handshake. A store to an address already queued
// overwrites that entry's data. The only exception is the head entry while
// it is being presented to memory. Cache miss lookups are answered from
// the buffer so a refill never returns stale memory contents.
//
// Ports
//   clk            clock, all state changes on the rising edge
//   rst_n          asynchronous active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data   store channel from the cache
//   rd_valid/rd_addr                    miss lookup request
//   rd_resp_valid/rd_hit/rd_data        lookup response, one cycle later
//   mem_req/mem_addr/mem_wdata/mem_ack  drain channel to memory
//   empty/count                         occupancy status
module cache_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_valid,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_resp_valid,
  output logic                     rd_hit,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t                 state_reg;
  logic                   valid_reg [DEPTH];
  logic [ADDR_W-1:0]      addr_reg  [DEPTH];
  logic [DATA_W-1:0]      data_reg  [DEPTH];
  logic [PTR_W-1:0]       head_reg, tail_reg;
  logic [CNT_W-1:0]       count_reg;

  logic                   valid_next [DEPTH];
  logic [ADDR_W-1:0]      addr_next  [DEPTH];
  logic [DATA_W-1:0]      data_next  [DEPTH];
  logic [PTR_W-1:0]       head_next, tail_next;
  logic [CNT_W-1:0]       count_next;

  logic                   push, pop, coalesce;
  logic [PTR_W-1:0]       coal_idx;
  logic                   hit_next;
  logic [DATA_W-1:0]      hit_data_next;

  assign wr_ready = (count_reg != CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;

  assign push = wr_valid && wr_ready;
  assign pop  = (state_reg == REQ) && mem_ack;

  // Coalesce target: any valid entry with the same address, except the head
  // while it is being presented (its data must stay stable on the bus).
  // Coalescing keeps at most one such entry, so no priority is needed.
  always_comb begin
    coalesce = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_reg[i] && (addr_reg[i] == wr_addr) &&
          !((state_reg == REQ) && (PTR_W'(i) == head_reg))) begin
        coalesce = 1'b1;
        coal_idx = PTR_W'(i);
      end
    end
  end

  // Post-edge view of the storage. The drain registers load from this so a
  // coalesce or append landing on the next head in the same cycle as a pop
  // is what gets presented to memory.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_next[i] = valid_reg[i];
      addr_next[i]  = addr_reg[i];
      data_next[i]  = data_reg[i];
    end
    head_next = head_reg;
    tail_next = tail_reg;
    if (pop) begin
      valid_next[head_reg] = 1'b0;
      head_next            = head_reg + PTR_W'(1);
    end
    if (push) begin
      if (coalesce) begin
        data_next[coal_idx] = wr_data;
      end else begin
        valid_next[tail_reg] = 1'b1;
        addr_next[tail_reg]  = wr_addr;
        data_next[tail_reg]  = wr_data;
        tail_next            = tail_reg + PTR_W'(1);
      end
    end
    count_next = count_reg + CNT_W'(push && !coalesce) - CNT_W'(pop);
  end

  // Lookup against pre-edge contents. Walk from head toward tail so the
  // youngest match is the last one assigned.
  always_comb begin
    hit_next      = 1'b0;
    hit_data_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_reg[head_reg + PTR_W'(k)] &&
          (addr_reg[head_reg + PTR_W'(k)] == rd_addr)) begin
        hit_next      = 1'b1;
        hit_data_next = data_reg[head_reg + PTR_W'(k)];
      end
    end
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_reg[i] <= 1'b0;
        addr_reg[i]  <= '0;
        data_reg[i]  <= '0;
      end
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_reg[i] <= valid_next[i];
        addr_reg[i]  <= addr_next[i];
        data_reg[i]  <= data_next[i];
      end
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Lookup response, one cycle after rd_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_resp_valid <= 1'b0;
      rd_hit        <= 1'b0;
      rd_data       <= '0;
    end else begin
      rd_resp_valid <= rd_valid;
      rd_hit        <= rd_valid && hit_next;
      rd_data       <= (rd_valid && hit_next) ? hit_data_next : '0;
    end
  end

  // Drain FSM. IDLE waits on the registered count, so a push into an empty
  // buffer raises mem_req one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (count_reg != '0) begin
            state_reg <= REQ;
            mem_req   <= 1'b1;
            mem_addr  <= addr_next[head_next];
            mem_wdata <= data_next[head_next];
          end
        end
        REQ: begin
          if (pop) begin
            if (count_next == '0) begin
              state_reg <= IDLE;
              mem_req   <= 1'b0;
            end else begin
              mem_addr  <= addr_next[head_next];
              mem_wdata <= data_next[head_next];
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          mem_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_write_buffer.sv
module tb_cache_write_buffer;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_resp_valid;
  logic              rd_hit;
  logic [DATA_W-1:0] rd_data;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic              empty;
  logic [$clog2(DEPTH):0] count;

  cache_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_hit(rd_hit), .rd_data(rd_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the buffer as an ordered list, oldest first.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              q[$];
  bit                m_req;
  bit                m_rvalid;
  bit                m_rhit;
  logic [DATA_W-1:0] m_rdata;

  task automatic model_clear();
    q.delete();
    m_req    = 0;
    m_rvalid = 0;
    m_rhit   = 0;
    m_rdata  = '0;
  endtask

  task automatic compare();
    check("count", 64'(count), 64'(q.size()));
    check("empty", 64'(empty), 64'(q.size() == 0));
    check("wr_ready", 64'(wr_ready), 64'(q.size() < DEPTH));
    check("mem_req", 64'(mem_req), 64'(m_req));
    if (m_req && q.size() > 0) begin
      check("mem_addr", 64'(mem_addr), 64'(q[0].addr));
      check("mem_wdata", 64'(mem_wdata), 64'(q[0].data));
    end
    check("rd_resp_valid", 64'(rd_resp_valid), 64'(m_rvalid));
    check("rd_hit", 64'(rd_hit), 64'(m_rhit));
    check("rd_data", 64'(rd_data), 64'(m_rdata));
  endtask

  // One clock: drive inputs, advance the model, clock, then compare.
  task automatic step(input bit wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input bit rv, input logic [ADDR_W-1:0] ra, input bit ack);
    int   n;
    int   j;
    bit   pop;
    bit   push;
    bit   hit;
    logic [DATA_W-1:0] hd;
    ent_t e;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra; mem_ack = ack;

    n  = q.size();
    hit = 0;
    hd  = '0;
    if (rv) begin
      for (int i = 0; i < n; i++) begin
        if (q[i].addr == ra) begin
          hit = 1;
          hd  = q[i].data;
        end
      end
    end
    pop  = m_req && ack;
    push = wv && (n < DEPTH);
    j = -1;
    if (push) begin
      for (int i = 0; i < n; i++) begin
        if (q[i].addr == wa && !(i == 0 && m_req)) j = i;
      end
    end
    if (push && j >= 0) begin
      e = q[j];
      e.data = wd;
      q[j] = e;
    end
    if (pop) begin
      $display("txn drain addr=0x%08h data=0x%08h", q[0].addr, q[0].data);
      void'(q.pop_front());
    end
    if (push && j < 0) q.push_back({wa, wd});
    if (!m_req) m_req = (n > 0);
    else        m_req = !(pop && q.size() == 0);
    m_rvalid = rv;
    m_rhit   = hit;
    m_rdata  = hd;

    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle(input bit ack);
    step(0, '0, '0, 0, '0, ack);
  endtask

  // Assert reset between edges and check that it acts without a clock.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_wr_ready", 64'(wr_ready), 64'(1));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_rd_resp_valid", 64'(rd_resp_valid), 64'(0));
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_valid = 0; wr_addr = '0; wr_data = '0;
    rd_valid = 0; rd_addr = '0; mem_ack = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    compare();
    check("reset_mem_wdata", 64'(mem_wdata), 64'(0));
    check("reset_rd_data", 64'(rd_data), 64'(0));

    // Single push, ack tied high
    step(1, 32'h10, 32'hAA, 0, '0, 1);
    idle(1);
    check("s1_req", 64'(mem_req), 64'(1));
    check("s1_addr", 64'(mem_addr), 64'h10);
    check("s1_data", 64'(mem_wdata), 64'hAA);
    idle(1);
    check("s1_empty", 64'(empty), 64'(1));
    idle(1);

    // Fill to full, dropped fifth push, ordered drain
    step(1, 32'h10, 32'd1, 0, '0, 0);
    step(1, 32'h14, 32'd2, 0, '0, 0);
    step(1, 32'h18, 32'd3, 0, '0, 0);
    step(1, 32'h1C, 32'd4, 0, '0, 0);
    check("s2_full_count", 64'(count), 64'(4));
    check("s2_full_ready", 64'(wr_ready), 64'(0));
    step(1, 32'h20, 32'd5, 0, '0, 0);
    check("s2_drop_count", 64'(count), 64'(4));
    for (int i = 0; i < 5; i++) idle(1);
    check("s2_drained", 64'(empty), 64'(1));

    // Coalescing around the in-flight head
    step(1, 32'h10, 32'd1, 0, '0, 0);
    step(1, 32'h20, 32'd2, 0, '0, 0);
    step(1, 32'h20, 32'd7, 0, '0, 0);
    check("s3_coal_count", 64'(count), 64'(2));
    step(1, 32'h10, 32'd9, 0, '0, 0);
    check("s3_append_count", 64'(count), 64'(3));

    // Lookups: youngest wins, miss returns zero
    step(0, '0, '0, 1, 32'h10, 0);
    check("s4_hit10", 64'(rd_hit), 64'(1));
    check("s4_data10", 64'(rd_data), 64'(9));
    step(0, '0, '0, 1, 32'h30, 0);
    check("s4_miss30", 64'(rd_hit), 64'(0));
    step(0, '0, '0, 1, 32'h20, 0);
    check("s4_data20", 64'(rd_data), 64'(7));

    // Same-cycle store is not visible; next-cycle lookup is
    step(1, 32'h40, 32'h55, 1, 32'h40, 0);
    check("s5_same_cycle", 64'(rd_hit), 64'(0));
    step(0, '0, '0, 1, 32'h40, 0);
    check("s5_next_cycle", 64'(rd_data), 64'h55);

    // Three pending with mem_req high, then reset between edges
    idle(1);
    check("s6_pending", 64'(count), 64'(3));
    async_reset();
    for (int i = 0; i < 3; i++) idle(1);
    check("s6_no_stale", 64'(mem_req), 64'(0));

    // Randomized traffic with varying memory back-pressure
    for (int c = 0; c < 1500; c++) begin
      bit ack;
      int mode;
      mode = (c / 150) % 3;
      if (mode == 0)      ack = 1;
      else if (mode == 1) ack = ($urandom_range(0, 1) == 1);
      else                ack = ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 2) != 0, ADDR_W'($urandom_range(0, 7)) << 2, $urandom,
           $urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, 9)) << 2, ack);
      if (c == 777) async_reset();
    end
    for (int i = 0; i < 8; i++) idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_write_buffer.md
# cache_write_buffer

Posted-write buffer between the 4-way cache and backing RAM. Accepts write-through stores from the cache, queues them in a small circular FIFO, and drains them one at a time to memory over a req/ack handshake. Coalesces repeated stores to the same address. On a cache read miss, it forwards buffered data so a refill never returns stale memory contents.

## Interface
- DEPTH, 4: number of buffer entries; power of two, 2 or more.
- ADDR_W, 32: address width.
- DATA_W, 32: data width.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low; one clock; reset is asynchronous and active-low.
- wr_valid  in  1  cache presents a store this cycle.
- wr_ready  out  1  buffer can accept a store; equals !full, derived from registered count.
- wr_addr  in  ADDR_W  store address.
- wr_data  in  DATA_W  store data.
- rd_valid  in  1  cache miss lookup request.
- rd_addr  in  ADDR_W  lookup address.
- rd_resp_valid  out  1  lookup result valid; asserted one cycle after rd_valid.
- rd_hit  out  1  lookup address matched a buffered entry.
- rd_data  out  DATA_W  forwarded data when rd_hit is 1, otherwise 0.
- mem_req  out  1  drain request to memory.
- mem_addr  out  ADDR_W  address of the head entry.
- mem_wdata  out  DATA_W  data of the head entry.
- mem_ack  in  1  memory accepted the current request.
- empty  out  1  no entries held.
- count  out  log2(DEPTH)+1  number of entries held.

## Operation
- Storage: per-entry valid, addr, and data. Head and tail pointers wrap modulo DEPTH. Address compare uses the full ADDR_W bits.
- Push: accepted when wr_valid and wr_ready are both 1 at a clock edge.
  - Coalesce: if a valid entry other than the in-flight head has the same address, overwrite its data in place. count is unchanged.
  - Otherwise, write the entry at tail, increment tail, and increment count.
  - A store to the in-flight head's address is appended as a new entry.
- Drain FSM, two states:
  - IDLE: mem_req=0. Go to REQ when count>0.
  - REQ: mem_req=1. mem_addr and mem_wdata show the head entry and stay stable until mem_ack is sampled high.
  - On mem_ack: pop the head (clear its valid, advance head, decrement count). Stay in REQ if entries remain; the next head is presented in the following cycle. Otherwise return to IDLE.
  - mem_ack is ignored in IDLE.
- Lookup: rd_valid is sampled at edge N and compared against entry contents as held before edge N.
  - A store accepted at edge N is not visible to that lookup.
  - An entry popped at edge N is still visible to that lookup.
  - If several entries match, which is possible only when the in-flight head matches, the youngest (closest to tail) wins.
- Simultaneous push and pop while not full: both take effect and count is unchanged.
- Full: wr_ready=0 even if a pop occurs in the same cycle. Stores presented while full are ignored.

## Timing
- Reset values: wr_ready=1, rd_resp_valid=0, rd_hit=0, rd_data=0, mem_req=0, mem_addr=0, mem_wdata=0, empty=1, count=0. FSM=IDLE, pointers=0, all valid bits=0.
- Reset mid-drain: all pending entries are discarded and mem_req drops immediately, without waiting for a clock.
- Drain latency: a push into an empty buffer at edge N gives mem_req=1 after edge N+1.
- Drain throughput: one entry per cycle when mem_ack is held at 1.
- Lookup latency: rd_valid at edge N gives rd_resp_valid, rd_hit, and rd_data after edge N, valid for exactly one cycle.
- count, empty, and wr_ready update after the edge that changes occupancy.

## Test plan
- Reset, then one push of addr 0x10 / data 0xAA with mem_ack tied to 1 -> mem_req high for one cycle with mem_addr 0x10 and mem_wdata 0xAA; then empty=1 and count=0.
- Hold mem_ack=0 and push 0x10/1, 0x14/2, 0x18/3, 0x1C/4 with DEPTH=4 -> count=4, wr_ready=0. A fifth push of 0x20/5 is dropped. Releasing mem_ack drains exactly 1, 2, 3, 4 in order.
- Hold mem_ack=0 and push 0x10/1 (becomes the in-flight head), then 0x20/2, then 0x20/7 -> count=2 and the 0x20 entry holds 7. A further push of 0x10/9 appends, giving count=3.
- After the previous scenario, look up 0x10 -> rd_hit=1 with rd_data=9 (youngest wins). Look up 0x30 -> rd_hit=0 with rd_data=0.
- Push 0x40/0x55 and look up 0x40 in the same cycle -> rd_hit=0. A lookup one cycle later -> rd_hit=1 with rd_data=0x55.
- With three entries pending and mem_req=1, assert rst_n=0 between clock edges -> mem_req=0, count=0, and empty=1 immediately. After release, no stale requests are issued.
